// File: rtl/divider_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding, default
// operand width and the iteration-counter width helper.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEF = 16;

    // Bits needed to count down from w-1 to 0 (never less than one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/nonrestoring_step.sv
// One radix-2 non-restoring iteration: shift the next dividend bit into the
// signed partial remainder, then subtract the divisor if the old remainder
// was non-negative or add it back if it was negative. The new quotient bit
// is the inverted sign of the result.
module nonrestoring_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH:0]   p_in,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   p_out,
    output logic             q_bit
);

    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] y_ext;

    // Remainder stays within [-Y, Y), so WIDTH+1 bits of two's complement
    // hold every result even though the shifted value may wrap.
    always_comb begin
        p_shift = {p_in[WIDTH-1:0], msb_in};
        y_ext   = {1'b0, y};
        if (p_in[WIDTH]) begin
            p_out = p_shift + y_ext;
        end else begin
            p_out = p_shift - y_ext;
        end
        q_bit = ~p_out[WIDTH];
    end

endmodule

// File: rtl/nonrestoring_divider_16.sv
// Sequential unsigned radix-2 non-restoring divider: Q = X / Y, R = X % Y,
// one quotient bit per clock, WIDTH+1 cycles from accept to done.
// Optional feature macro: DIVIDER_STICKY_EN (builds the inexact/sticky flag;
// when undefined sticky is tied low).
//
// Handshake: start is a request that is accepted on any rising edge where the
// FSM is IDLE (busy==0, which includes the done cycle); it is neither queued
// nor acknowledged while busy. done is a one-cycle valid strobe with no
// backpressure; Q, R, div_by_zero and sticky are valid with it and held until
// the next done. Divide-by-zero completes in the cycle after accept.
module nonrestoring_divider_16
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero,
    output logic             sticky
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state;
    div_state_t       state_next;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   p_step;
    logic             q_bit;
    logic [WIDTH-1:0] r_fix;
    logic             y_zero;

    nonrestoring_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in   (p_reg),
        .msb_in (q_sh[WIDTH-1]),
        .y      (d_reg),
        .p_out  (p_step),
        .q_bit  (q_bit)
    );

    // Final remainder correction: a negative partial remainder gets Y added
    // back; the true result lies in [0, Y) so WIDTH bits suffice.
    always_comb begin
        y_zero = (Y == '0);
        if (p_reg[WIDTH]) begin
            r_fix = p_reg[WIDTH-1:0] + d_reg;
        end else begin
            r_fix = p_reg[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a zero divisor finishes without leaving IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !y_zero) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers; done is a single-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg       <= '0;
            q_sh        <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!y_zero) begin
                            q_sh  <= X;
                            d_reg <= Y;
                            p_reg <= '0;
                            cnt   <= CNT_W'(WIDTH - 1);
                            busy  <= 1'b1;
                        end else begin
                            Q           <= '1;
                            R           <= X;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    p_reg <= p_step;
                    q_sh  <= {q_sh[WIDTH-2:0], q_bit};
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    Q           <= q_sh;
                    R           <= r_fix;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIVIDER_STICKY_EN
    logic sticky_reg;

    // Inexact flag, updated only on the same edges that update R.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (state == IDLE && start && y_zero) begin
            sticky_reg <= (X != '0);
        end else if (state == FIX) begin
            sticky_reg <= (r_fix != '0);
        end
    end

    assign sticky = sticky_reg;
`else
    assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_nonrestoring_divider_16.sv
// Bench for nonrestoring_divider_16: directed vectors with literal results,
// a cycle-level arithmetic model (X/Y, X%Y plus fixed latency) compared
// against every output on every falling edge, and a short random sweep.
module tb_nonrestoring_divider_16;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;
    logic         sticky;

    int n_chk = 0;
    int n_err = 0;

    nonrestoring_divider_16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .X           (x_in),
        .Y           (y_in),
        .busy        (busy),
        .done        (done),
        .Q           (q),
        .R           (r),
        .div_by_zero (div_by_zero),
        .sticky      (sticky)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sticky_of(input logic [W-1:0] rem);
`ifdef DIVIDER_STICKY_EN
        return (rem != '0);
`else
        return 1'b0;
`endif
    endfunction

    // model: arithmetic result queued at accept, released LAT edges later
    logic [2*W-1:0] exp_q[$];
    int             m_cnt    = 0;
    logic           m_busy   = 1'b0;
    logic           m_done   = 1'b0;
    logic [W-1:0]   m_q      = '0;
    logic [W-1:0]   m_r      = '0;
    logic           m_dbz    = 1'b0;
    logic           m_sticky = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_busy = 0; m_done = 0; m_q = '0; m_r = '0;
            m_dbz = 0; m_sticky = 0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_q, m_r} = exp_q.pop_front();
                    m_done   = 1'b1;
                    m_busy   = 1'b0;
                    m_dbz    = 1'b0;
                    m_sticky = sticky_of(m_r);
                end
            end else if (start === 1'b1) begin
                if (y_in == '0) begin
                    m_q = '1; m_r = x_in; m_dbz = 1'b1;
                    m_sticky = sticky_of(x_in);
                    m_done = 1'b1;
                end else begin
                    exp_q.push_back({x_in / y_in, x_in % y_in});
                    m_cnt  = LAT;
                    m_busy = 1'b1;
                end
            end
        end
    end

    // compare process: every output, every cycle
    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("q", q, m_q);
        check("r", r, m_r);
        check("div_by_zero", div_by_zero, m_dbz);
        check("sticky", sticky, m_sticky);
    end

    // driver tasks (called at a falling edge)
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        @(negedge clk);
        start_op(x, y);
        wait_done(lat);
        check({name, "_lat"}, lat, (y == '0) ? 0 : LAT);
        check({name, "_q"}, q, eq);
        check({name, "_r"}, r, er);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [W-1:0] rx, ry;

        rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_sticky", sticky, 0);
        rst = 1'b0;

        // 1000 / 7
        run_check("d1000_7", 16'd1000, 16'd7, 16'd142, 16'd6);
        check("d1000_7_dbz", div_by_zero, 0);
        check("d1000_7_sticky", sticky, sticky_of(16'd6));

        run_check("dffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
        check("dffff_1_sticky", sticky, 0);
        run_check("d5_9", 16'h0005, 16'h0009, 16'h0000, 16'h0005);
        run_check("d300_300", 16'd300, 16'd300, 16'd1, 16'd0);
        run_check("d65535_255", 16'hFFFF, 16'd255, 16'd257, 16'd0);
        run_check("d65534_65535", 16'hFFFE, 16'hFFFF, 16'd0, 16'hFFFE);
        run_check("d40000_3", 16'd40000, 16'd3, 16'd13333, 16'd1);

        // divide by zero: done right after accept, busy never rises
        @(negedge clk);
        start_op(16'h1234, 16'h0000);
        check("dz_done", done, 1);
        check("dz_busy", busy, 0);
        check("dz_q", q, 16'hFFFF);
        check("dz_r", r, 16'h1234);
        check("dz_flag", div_by_zero, 1);
        check("dz_sticky", sticky, sticky_of(16'h1234));
        @(negedge clk);
        check("dz_busy_next", busy, 0);
        check("dz_done_next", done, 0);

        // start while busy is ignored; start in done cycle is accepted
        @(negedge clk);
        start_op(16'd100, 16'd3);
        repeat (4) @(negedge clk);
        start_op(16'd9, 16'd2);
        wait_done(lat);
        check("ign_q", q, 16'd33);
        check("ign_r", r, 16'd1);
        start_op(16'd77, 16'd8);
        wait_done(lat);
        check("b2b_lat", lat, LAT);
        check("b2b_q", q, 16'd9);
        check("b2b_r", r, 16'd5);

        // async reset mid-calculation
        @(negedge clk);
        start_op(16'd12345, 16'd7);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", q, 0);
        check("arst_r", r, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("arst_no_done", done_seen, 0);
        run_check("d50000_250", 16'd50000, 16'd250, 16'd200, 16'd0);

        // random sweep including small divisors and zero
        for (int i = 0; i < 300; i++) begin
            rx = 16'($urandom_range(0, 65535));
            if (i % 23 == 0) ry = '0;
            else if (i % 3 == 0) ry = 16'($urandom_range(1, 15));
            else ry = 16'($urandom_range(1, 65535));
            run_check("rand", rx, ry, (ry == '0) ? 16'hFFFF : rx / ry, (ry == '0) ? rx : rx % ry);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
